// File: rtl/param_exec_unit.sv
// Parametrised single-issue execution unit: valid/ready in and out,
// 1-cycle and MUL_LAT-cycle ops, optional saturation, ovf/err flags.
module param_exec_unit #(
  parameter int DW      = 8,
  parameter int MUL_LAT = 3,
  parameter bit SAT_EN  = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      op,
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*DW-1:0] result,
  output logic            ovf,
  output logic            err,
  output logic            busy
);

  localparam int W2 = 2 * DW;
  localparam int XW = 2 * DW + 3;
  localparam int CW = (MUL_LAT < 2) ? 1 : $clog2(MUL_LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_HOLD
  } state_t;

  state_t r_state;
  state_t w_state_nx;

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nx;
  logic [3:0]    r_op;
  logic [DW-1:0] r_a;
  logic [DW-1:0] r_b;

  logic          w_acc;
  logic          w_multi;
  logic          w_load;
  logic [3:0]    w_op;
  logic [DW-1:0] w_a;
  logic [DW-1:0] w_b;
  logic [DW-1:0] w_xn;
  logic [W2-1:0] w_cat;
  logic [XW-1:0] w_ea;
  logic [XW-1:0] w_eb;
  logic [XW-1:0] w_prod;
  logic [XW-1:0] w_p4;
  logic [XW-1:0] w_raw;
  logic [W2-1:0] w_res;
  logic          w_uf;
  logic          w_of;
  logic          w_ill;

  assign in_ready = (r_state == S_IDLE);
  assign busy     = (r_state != S_IDLE);
  assign w_acc    = in_valid && in_ready;
  assign w_multi  = op inside {4'd4, 4'd7, 4'd8, 4'd9, 4'd10};

  // IDLE computes from live inputs; EXEC from the operands latched at accept
  assign w_op   = in_ready ? op : r_op;
  assign w_a    = in_ready ? a : r_a;
  assign w_b    = in_ready ? b : r_b;
  assign w_xn   = w_a ^ ~w_b;
  assign w_cat  = {w_a, w_b};
  assign w_ea   = XW'(w_a);
  assign w_eb   = XW'(w_b);
  assign w_prod = w_ea * w_eb;
  assign w_p4   = w_prod << 2;

  always_comb begin
    w_raw = '0;
    w_uf  = 1'b0;
    w_of  = 1'b0;
    w_ill = 1'b0;
    case (w_op)
      4'd0: w_raw = '0;
      4'd1: w_raw = w_ea + w_eb;
      4'd2: w_raw = w_ea & w_eb;
      4'd3: begin
        w_raw = w_ea - w_eb;
        w_uf  = (w_a < w_b);
      end
      4'd4: w_raw = w_prod;
      4'd5: w_raw = XW'(w_cat >> 1);
      4'd6: begin
        w_raw = XW'({w_cat[W2-2:0], 1'b0});
        w_of  = w_a[DW-1];
      end
      4'd7: begin
        w_raw = w_prod - w_ea;
        w_uf  = (w_prod < w_ea);
      end
      4'd8: begin
        w_raw = w_p4 - w_ea;
        w_uf  = (w_p4 < w_ea);
        w_of  = !w_uf && (w_raw[XW-1:W2] != '0);
      end
      4'd9:  w_raw = w_prod + w_ea;
      4'd10: w_raw = w_ea + (w_ea << 1);
      4'd11: w_raw = w_ea ^ w_eb;
      4'd12: w_raw = w_ea | w_eb;
      4'd13: w_raw = XW'(w_xn);
      default: w_ill = 1'b1;
    endcase
  end

  always_comb begin
    w_res = w_raw[W2-1:0];
    if (SAT_EN && w_uf) begin
      w_res = '0;
    end else if (SAT_EN && w_of) begin
      w_res = '1;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_load     = 1'b0;
    unique case (1'b1)
      (r_state == S_IDLE): begin
        if (w_acc) begin
          if (w_multi && (MUL_LAT > 1)) begin
            w_state_nx = S_EXEC;
            w_cnt_nx   = CW'(MUL_LAT - 1);
          end else begin
            w_state_nx = S_HOLD;
            w_load     = 1'b1;
          end
        end
      end
      (r_state == S_EXEC): begin
        if (r_cnt <= CW'(1)) begin
          w_state_nx = S_HOLD;
          w_cnt_nx   = '0;
          w_load     = 1'b1;
        end else begin
          w_cnt_nx = r_cnt - CW'(1);
        end
      end
      (r_state == S_HOLD): begin
        if (out_ready) begin
          w_state_nx = S_IDLE;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_op      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      ovf       <= 1'b0;
      err       <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      if (w_acc) begin
        r_op <= op;
        r_a  <= a;
        r_b  <= b;
      end
      if (w_load) begin
        out_valid <= 1'b1;
        result    <= w_res;
        ovf       <= w_uf || w_of;
        err       <= w_ill;
      end else if ((r_state == S_HOLD) && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_param_exec_unit.sv
// Directed bench for param_exec_unit: one wrap instance and one
// saturating instance share the same stimulus.
module tb_param_exec_unit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [3:0]  op;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_ready;

  logic        rdy0, ov0, ovf0, err0, busy0;
  logic [15:0] res0;
  logic        rdy1, ov1, ovf1, err1, busy1;
  logic [15:0] res1;

  int n_tests;
  int n_fail;

  typedef struct {
    logic [3:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] r0;
    logic        o0;
    logic [15:0] r1;
    logic        o1;
    logic        e;
    int          lat;
  } vec_t;

  param_exec_unit #(.DW(8), .MUL_LAT(3), .SAT_EN(1'b0)) u0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(rdy0),
    .op(op), .a(a), .b(b),
    .out_valid(ov0), .out_ready(out_ready),
    .result(res0), .ovf(ovf0), .err(err0), .busy(busy0)
  );

  param_exec_unit #(.DW(8), .MUL_LAT(3), .SAT_EN(1'b1)) u1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(rdy1),
    .op(op), .a(a), .b(b),
    .out_valid(ov1), .out_ready(out_ready),
    .result(res1), .ovf(ovf1), .err(err1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] o, input logic [7:0] x,
                       input logic [7:0] y);
    op = o; a = x; b = y; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    n_tests++;
    if ({ov0, res0, ovf0, err0, busy0, rdy0} !== {1'b0, 16'h0, 3'b000, 1'b1}) begin
      n_fail++;
      $display("FAIL reset: ov=%b res=%h ovf=%b err=%b busy=%b rdy=%b want 0 0000 0 0 0 1",
               ov0, res0, ovf0, err0, busy0, rdy0);
    end
  endtask

  task automatic test_add();
    issue(4'd1, 8'd200, 8'd100);
    n_tests++;
    if ({ov0, res0, ovf0, err0, rdy0} !== {1'b1, 16'h012C, 3'b000}) begin
      n_fail++;
      $display("FAIL add: ov=%b res=%h ovf=%b err=%b rdy=%b want 1 012c 0 0 0",
               ov0, res0, ovf0, err0, rdy0);
    end
    step();
    n_tests++;
    if ({ov0, rdy0} !== 2'b01) begin
      n_fail++;
      $display("FAIL add_idle: ov=%b rdy=%b want 0 1", ov0, rdy0);
    end
  endtask

  task automatic test_mul();
    issue(4'd4, 8'd255, 8'd255);
    for (int k = 1; k < 3; k++) begin
      a = 8'(k * 17);
      b = 8'(k * 3);
      n_tests++;
      if ({ov0, rdy0, busy0} !== 3'b001) begin
        n_fail++;
        $display("FAIL mul_exec%0d: ov=%b rdy=%b busy=%b want 0 0 1",
                 k, ov0, rdy0, busy0);
      end
      step();
    end
    n_tests++;
    if ({ov0, res0, ovf0, rdy0} !== {1'b1, 16'hFE01, 2'b00}) begin
      n_fail++;
      $display("FAIL mul: ov=%b res=%h ovf=%b rdy=%b want 1 fe01 0 0",
               ov0, res0, ovf0, rdy0);
    end
    step();
  endtask

  task automatic test_sf2_sat();
    issue(4'd8, 8'd255, 8'd255);
    step();
    step();
    n_tests++;
    if ({ov0, res0, ovf0} !== {1'b1, 16'hF705, 1'b1}) begin
      n_fail++;
      $display("FAIL sf2_wrap: ov=%b res=%h ovf=%b want 1 f705 1", ov0, res0, ovf0);
    end
    n_tests++;
    if ({ov1, res1, ovf1} !== {1'b1, 16'hFFFF, 1'b1}) begin
      n_fail++;
      $display("FAIL sf2_sat: ov=%b res=%h ovf=%b want 1 ffff 1", ov1, res1, ovf1);
    end
    step();
  endtask

  task automatic test_sub_shl();
    issue(4'd3, 8'd5, 8'd10);
    n_tests++;
    if ({res0, ovf0} !== {16'hFFFB, 1'b1}) begin
      n_fail++;
      $display("FAIL sub_wrap: res=%h ovf=%b want fffb 1", res0, ovf0);
    end
    n_tests++;
    if ({res1, ovf1} !== {16'h0000, 1'b1}) begin
      n_fail++;
      $display("FAIL sub_sat: res=%h ovf=%b want 0000 1", res1, ovf1);
    end
    step();
    issue(4'd6, 8'h80, 8'h01);
    n_tests++;
    if ({ov0, res0, ovf0} !== {1'b1, 16'h0002, 1'b1}) begin
      n_fail++;
      $display("FAIL shl: ov=%b res=%h ovf=%b want 1 0002 1", ov0, res0, ovf0);
    end
    step();
  endtask

  task automatic test_hold();
    out_ready = 1'b0;
    issue(4'd11, 8'h0F, 8'hFF);
    op = 4'd1; a = 8'd1; b = 8'd1; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      n_tests++;
      if ({ov0, res0, rdy0} !== {1'b1, 16'h00F0, 1'b0}) begin
        n_fail++;
        $display("FAIL hold%0d: ov=%b res=%h rdy=%b want 1 00f0 0",
                 k, ov0, res0, rdy0);
      end
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    n_tests++;
    if ({ov0, rdy0, busy0, res0} !== {3'b010, 16'h00F0}) begin
      n_fail++;
      $display("FAIL hold_release: ov=%b rdy=%b busy=%b res=%h want 0 1 0 00f0",
               ov0, rdy0, busy0, res0);
    end
  endtask

  task automatic test_rst_exec();
    issue(4'd4, 8'd200, 8'd3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_tests++;
    if ({ov0, res0, busy0, rdy0} !== {1'b0, 16'h0, 2'b01}) begin
      n_fail++;
      $display("FAIL rst_exec: ov=%b res=%h busy=%b rdy=%b want 0 0000 0 1",
               ov0, res0, busy0, rdy0);
    end
    step();
    step();
    n_tests++;
    if ({ov0, busy0} !== 2'b00) begin
      n_fail++;
      $display("FAIL rst_discard: ov=%b busy=%b want 0 0", ov0, busy0);
    end
    issue(4'd15, 8'h12, 8'h34);
    n_tests++;
    if ({ov0, res0, err0, ov1, err1} !== {1'b1, 16'h0, 1'b1, 2'b11}) begin
      n_fail++;
      $display("FAIL illegal: ov=%b res=%h err=%b ov1=%b err1=%b want 1 0000 1 1 1",
               ov0, res0, err0, ov1, err1);
    end
    step();
  endtask

  task automatic test_ops();
    vec_t v[13];
    v[0]  = '{4'd2,  8'hF0, 8'h3C, 16'h0030, 1'b0, 16'h0030, 1'b0, 1'b0, 1};
    v[1]  = '{4'd5,  8'h12, 8'h34, 16'h091A, 1'b0, 16'h091A, 1'b0, 1'b0, 1};
    v[2]  = '{4'd12, 8'h0F, 8'hA0, 16'h00AF, 1'b0, 16'h00AF, 1'b0, 1'b0, 1};
    v[3]  = '{4'd13, 8'h0F, 8'hFF, 16'h000F, 1'b0, 16'h000F, 1'b0, 1'b0, 1};
    v[4]  = '{4'd0,  8'h55, 8'h66, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1};
    v[5]  = '{4'd7,  8'h0A, 8'h14, 16'h00BE, 1'b0, 16'h00BE, 1'b0, 1'b0, 3};
    v[6]  = '{4'd7,  8'h07, 8'h00, 16'hFFF9, 1'b1, 16'h0000, 1'b1, 1'b0, 3};
    v[7]  = '{4'd9,  8'hFF, 8'hFF, 16'hFF00, 1'b0, 16'hFF00, 1'b0, 1'b0, 3};
    v[8]  = '{4'd10, 8'hC8, 8'h00, 16'h0258, 1'b0, 16'h0258, 1'b0, 1'b0, 3};
    v[9]  = '{4'd8,  8'h03, 8'h05, 16'h0039, 1'b0, 16'h0039, 1'b0, 1'b0, 3};
    v[10] = '{4'd1,  8'hFF, 8'hFF, 16'h01FE, 1'b0, 16'h01FE, 1'b0, 1'b0, 1};
    v[11] = '{4'd3,  8'h0A, 8'h05, 16'h0005, 1'b0, 16'h0005, 1'b0, 1'b0, 1};
    v[12] = '{4'd14, 8'hAA, 8'hBB, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 1};
    foreach (v[i]) begin
      issue(v[i].op, v[i].a, v[i].b);
      for (int k = 1; k < v[i].lat; k++) begin
        n_tests++;
        if (ov0 !== 1'b0) begin
          n_fail++;
          $display("FAIL op%0d_early: ov=%b want 0 at cycle %0d", i, ov0, k);
        end
        step();
      end
      n_tests++;
      if ({ov0, res0, ovf0, err0} !== {1'b1, v[i].r0, v[i].o0, v[i].e}) begin
        n_fail++;
        $display("FAIL op%0d_wrap: ov=%b res=%h ovf=%b err=%b want 1 %h %b %b",
                 i, ov0, res0, ovf0, err0, v[i].r0, v[i].o0, v[i].e);
      end
      n_tests++;
      if ({res1, ovf1, err1} !== {v[i].r1, v[i].o1, v[i].e}) begin
        n_fail++;
        $display("FAIL op%0d_sat: res=%h ovf=%b err=%b want %h %b %b",
                 i, res1, ovf1, err1, v[i].r1, v[i].o1, v[i].e);
      end
      step();
    end
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    op        = 4'd0;
    a         = 8'd0;
    b         = 8'd0;
    out_ready = 1'b1;
    test_reset();
    test_add();
    test_mul();
    test_sf2_sat();
    test_sub_shl();
    test_hold();
    test_rst_exec();
    test_ops();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/param_exec_unit.md
Name: param_exec_unit

Overview:
- Parametrised single-issue execution unit for the multicore datapath, replacing the fixed 8-bit ALU.
- Operand width is configurable. Multi-cycle latency is configurable.
- Uses valid/ready handshakes on both input and output, and supports output backpressure.
- Adds optional saturation, an overflow flag and illegal-opcode reporting.

Parameters:
- DW, 8, operand width in bits (>=2); result width is 2*DW.
- MUL_LAT, 3, cycles from accept to out_valid for multi-cycle ops (>=1).
- SAT_EN, 0, 1 = clamp under/overflow to 0 / all-ones, 0 = wrap modulo 2^(2*DW).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept; high only in IDLE.
- op  in  4  opcode (encoding under Behaviour).
- a  in  DW  operand A.
- b  in  DW  operand B.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- result  out  2*DW  result, zero-extended operands.
- ovf  out  1  wrap or saturation occurred; qualified by out_valid.
- err  out  1  illegal opcode; qualified by out_valid.
- busy  out  1  state != IDLE.

Behaviour:
- Reset, synchronous: state=IDLE, out_valid=0, result=0, ovf=0, err=0, counter=0, busy=0, in_ready=1. Reset applies in any state, mid-EXEC or HOLD; the in-flight op is discarded.
- Accept: in_valid && in_ready at a rising edge. op, a and b are latched at accept; later input changes are ignored until the next accept.
- FSM states:
  - IDLE: in_ready=1. On accept of a 1-cycle op -> HOLD. On accept of a multi-cycle op -> EXEC with counter=MUL_LAT-1. If MUL_LAT=1 -> HOLD directly.
  - EXEC: counter decrements each cycle; at 1 -> HOLD with result loaded.
  - HOLD: out_valid=1. result, ovf and err are stable while out_ready=0. On out_ready=1 -> IDLE and out_valid=0 next cycle.
- No accept in EXEC or HOLD. Minimum spacing is latency+1 cycles per op.
- Latency: 1-cycle ops raise out_valid in the cycle after accept. Multi-cycle ops raise out_valid MUL_LAT cycles after accept.
- Opcodes: all arithmetic is on 2*DW-bit zero-extended operands; cycle count in brackets.
  - 0 NOP: result 0 [1].
  - 1 ADD: a+b [1].
  - 2 AND: a&b [1].
  - 3 SUB: a-b [1].
  - 4 MUL: a*b [M].
  - 5 SHR: {a,b}>>1 [1].
  - 6 SHL: {a,b}<<1 [1].
  - 7 SF1: a*b-a [M].
  - 8 SF2: 4*a*b-a [M].
  - 9 SF3: a*b+a [M].
  - 10 SF4: 3*a [M].
  - 11 XOR: a^b [1].
  - 12 OR: a|b [1].
  - 13 XNOR: zero-extend(a ^ ~b), DW bits [1].
  - 14, 15 illegal: result 0, err=1 [1].
- ovf rules:
  - SUB/SF1/SF2: ovf=1 on underflow (true result negative). SF2 also sets ovf=1 when 4*a*b-a >= 2^(2*DW).
  - SHL: ovf = bit 2*DW-1 of {a,b}.
  - All other ops: ovf=0.
- SAT_EN=0: result wraps modulo 2^(2*DW).
- SAT_EN=1: underflow -> 0; overflow -> all-ones. ovf is still reported.
- err=0 for all legal ops.
- out_valid, result, ovf and err are registered outputs. in_ready and busy decode from state only, with no combinational path from in_valid or out_ready.

Test Plan:
DW=8, MUL_LAT=3, out_ready=1 unless stated.
1. ADD a=200 b=100 -> out_valid in the cycle after accept; result=0x012C, ovf=0, err=0; back to IDLE, in_ready=1, the cycle after that.
2. MUL a=255 b=255; change a/b every cycle during EXEC -> out_valid exactly 3 cycles after accept; result=0xFE01; in_ready=0 throughout.
3. SF2 a=255 b=255 -> SAT_EN=0: result=0xF705, ovf=1. SAT_EN=1: result=0xFFFF, ovf=1.
4. SUB a=5 b=10 -> SAT_EN=0: result=0xFFFB, ovf=1. SAT_EN=1: result=0x0000, ovf=1. SHL a=0x80 b=0x01 -> result=0x0002, ovf=1.
5. XOR a=0x0F b=0xFF with out_ready=0 for 5 cycles -> out_valid held, result=0x00F0 stable, in_ready=0; an in_valid with op=ADD asserted during HOLD is not accepted. Raise out_ready -> IDLE next cycle.
6. rst pulsed 1 cycle during EXEC of MUL -> next cycle out_valid=0, result=0, busy=0, in_ready=1. op=15 -> result=0, err=1 after 1 cycle.
